// File: rtl/data_sram_resp_pkg.sv
// Shared state encodings and default parameters for the data-SRAM responder.
package data_sram_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int          DEFAULT_TIMEOUT  = 64;
  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/data_sram_resp_wait_counter.sv
// Watchdog counter: cleared when an access is accepted, counts while the
// access is outstanding, and flags the last permitted wait cycle.
module data_sram_resp_wait_counter #(
  parameter int TIMEOUT = 64,
  localparam int WIDTH  = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/data_sram_resp.sv
// CPU data-SRAM port responder: forwards each access to a variable-latency
// backing memory, stalls the pipeline while it is outstanding, and times out.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          TIMEOUT  = DEFAULT_TIMEOUT,
  parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err
);

  state_t state;
  state_t next_state;
  logic   accept;
  logic   terminal;
  logic   finish;

  assign accept = ((state == IDLE) || (state == RESP)) && data_sram_en;
  // An ack on the terminal cycle still counts as a normal completion.
  assign finish = (state == BUSY) && (mem_ack || terminal);

  data_sram_resp_wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .enable   (state == BUSY),
    .terminal (terminal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE, RESP: next_state = data_sram_en ? BUSY : IDLE;
      BUSY:       next_state = (mem_ack || terminal) ? RESP : BUSY;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    stallreq = (state == BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_sram_rdata <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_wstrb       <= '0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      timeout_err     <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      if (accept) begin
        mem_req   <= 1'b1;
        mem_we    <= |data_sram_wen;
        mem_wstrb <= data_sram_wen;
        mem_addr  <= data_sram_addr & ~32'h3;
        mem_wdata <= data_sram_wdata;
      end else if (finish) begin
        mem_req <= 1'b0;
        if (!mem_we) begin
          data_sram_rdata <= mem_ack ? mem_rdata : ERR_DATA;
        end
        if (!mem_ack) begin
          timeout_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed self-checking bench for data_sram_resp with a short watchdog.
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        timeout_err;

  int tests_run = 0;
  int tests_failed = 0;

  data_sram_resp #(
    .TIMEOUT  (8),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .stallreq        (stallreq),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_wstrb       (mem_wstrb),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] wen,
                               input logic [31:0] addr, input logic [31:0] wdata);
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
  endtask

  initial begin
    rst       = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0);
    step();
    step();
    checkOutput("reset_rdata",   data_sram_rdata, 32'h0);
    checkOutput("reset_stall",   32'(stallreq), 32'h0);
    checkOutput("reset_req",     32'(mem_req), 32'h0);
    checkOutput("reset_we",      32'(mem_we), 32'h0);
    checkOutput("reset_wstrb",   32'(mem_wstrb), 32'h0);
    checkOutput("reset_addr",    mem_addr, 32'h0);
    checkOutput("reset_wdata",   mem_wdata, 32'h0);
    checkOutput("reset_timeout", 32'(timeout_err), 32'h0);
    rst = 1'b0;

    // Read with a one-cycle ack
    applyStimulus(1'b1, 4'b0000, 32'h0000_1004, 32'h0);
    step();
    applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0);
    checkOutput("rd1_stall", 32'(stallreq), 32'h1);
    checkOutput("rd1_req",   32'(mem_req), 32'h1);
    checkOutput("rd1_addr",  mem_addr, 32'h0000_1004);
    checkOutput("rd1_we",    32'(mem_we), 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 1'b0;
    checkOutput("rd1_stall_resp", 32'(stallreq), 32'h0);
    checkOutput("rd1_req_drop",   32'(mem_req), 32'h0);
    checkOutput("rd1_rdata",      data_sram_rdata, 32'h1234_5678);
    step();
    checkOutput("rd1_rdata_held", data_sram_rdata, 32'h1234_5678);

    // Byte store with a five-cycle ack
    applyStimulus(1'b1, 4'b0010, 32'h0000_2003, 32'h0000_AB00);
    step();
    applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0);
    checkOutput("st_we",    32'(mem_we), 32'h1);
    checkOutput("st_wstrb", 32'(mem_wstrb), 32'h2);
    checkOutput("st_addr",  mem_addr, 32'h0000_2000);
    checkOutput("st_wdata", mem_wdata, 32'h0000_AB00);
    for (int i = 0; i < 5; i++) begin
      checkOutput("st_stall_busy", 32'(stallreq), 32'h1);
      if (i == 4) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h9999_9999;
      end
      step();
    end
    mem_ack = 1'b0;
    checkOutput("st_stall_done", 32'(stallreq), 32'h0);
    checkOutput("st_req_drop",   32'(mem_req), 32'h0);
    checkOutput("st_rdata_kept", data_sram_rdata, 32'h1234_5678);

    // Back-to-back reads, second one issued in the RESP cycle
    applyStimulus(1'b1, 4'b0000, 32'h0000_3000, 32'h0);
    step();
    applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_1111;
    step();
    mem_ack = 1'b0;
    checkOutput("b2b_rdata1", data_sram_rdata, 32'h1111_1111);
    checkOutput("b2b_resp",   32'(stallreq), 32'h0);
    applyStimulus(1'b1, 4'b0000, 32'h0000_3004, 32'h0);
    step();
    applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0);
    checkOutput("b2b_no_bubble", 32'(stallreq), 32'h1);
    checkOutput("b2b_addr2",     mem_addr, 32'h0000_3004);
    mem_ack   = 1'b1;
    mem_rdata = 32'h2222_2222;
    step();
    mem_ack = 1'b0;
    checkOutput("b2b_rdata2", data_sram_rdata, 32'h2222_2222);

    // Timeout on a read with no ack
    applyStimulus(1'b1, 4'b0000, 32'h0000_4000, 32'h0);
    step();
    applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("to_req_busy", 32'(mem_req), 32'h1);
      checkOutput("to_no_err",   32'(timeout_err), 32'h0);
      step();
    end
    checkOutput("to_req_drop", 32'(mem_req), 32'h0);
    checkOutput("to_err",      32'(timeout_err), 32'h1);
    checkOutput("to_rdata",    data_sram_rdata, 32'hDEAD_BEEF);
    checkOutput("to_stall",    32'(stallreq), 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_5555;
    step();
    mem_ack = 1'b0;
    checkOutput("to_err_once",   32'(timeout_err), 32'h0);
    checkOutput("to_late_ack",   data_sram_rdata, 32'hDEAD_BEEF);
    checkOutput("to_late_stall", 32'(stallreq), 32'h0);
    checkOutput("to_late_req",   32'(mem_req), 32'h0);

    // Ack on the terminal watchdog cycle
    applyStimulus(1'b1, 4'b0000, 32'h0000_5000, 32'h0);
    step();
    applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0);
    for (int i = 0; i < 7; i++) begin
      checkOutput("term_stall", 32'(stallreq), 32'h1);
      step();
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_0001;
    step();
    mem_ack = 1'b0;
    checkOutput("term_rdata", data_sram_rdata, 32'hCAFE_0001);
    checkOutput("term_no_err", 32'(timeout_err), 32'h0);
    step();
    checkOutput("term_no_err_after", 32'(timeout_err), 32'h0);

    // Reset while BUSY, then a stray ack
    applyStimulus(1'b1, 4'b0000, 32'h0000_6000, 32'h0);
    step();
    applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0);
    checkOutput("rst_busy_stall", 32'(stallreq), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rst_req",   32'(mem_req), 32'h0);
    checkOutput("rst_stall", 32'(stallreq), 32'h0);
    checkOutput("rst_rdata", data_sram_rdata, 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h7777_7777;
    step();
    mem_ack = 1'b0;
    checkOutput("rst_ack_stall", 32'(stallreq), 32'h0);
    checkOutput("rst_ack_req",   32'(mem_req), 32'h0);
    checkOutput("rst_ack_rdata", data_sram_rdata, 32'h0);
    step();
    checkOutput("rst_ack_idle", 32'(stallreq), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
